// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU control decoder and the
// execute unit, plus the execute-unit FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_SLL = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle combinational ALU core: AND/OR/ADD/SUB/SLT/NOR, illegal-code
// detection and signed overflow. SLL is a legal code here but is computed by the
// iterative shifter in the execute unit, so the core returns 0 for it.
// Optional feature macro: ALU_OVF_EN (signed overflow flag for ADD/SUB).
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = opa + opb;
  assign diff = opa - opb;

  // Select the operation result; any code outside the defined set is flagged illegal with a zero result
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctl)
      ALU_AND: result = opa & opb;
      ALU_OR:  result = opa | opb;
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_NOR: result = ~(opa | opb);
      ALU_SLL: result = '0;
      default: illegal = 1'b1;
    endcase
  end

`ifdef ALU_OVF_EN
  // Signed overflow: ADD with same-sign operands whose sum flips sign, SUB with opposite-sign operands whose difference differs in sign from opa
  always_comb begin
    ovf = 1'b0;
    case (alu_ctl)
      ALU_ADD: ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      ALU_SUB: ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Single-cycle ops
// return a registered result one cycle after accept; SLL uses an iterative
// 1-bit-per-cycle shifter so the result appears shamt+1 cycles after accept.
// Optional feature macro: ALU_OVF_EN (signed overflow flag for ADD/SUB).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctl,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               ovf
);

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   result_q;
  logic               illegal_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   core_result;
  logic               core_illegal;
  logic               core_ovf;

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_ctl(alu_ctl),
    .opa    (opa),
    .opb    (opb),
    .result (core_result),
    .illegal(core_illegal),
    .ovf    (core_ovf)
  );

  // State register; reset aborts any shift or pending result
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Handshake outputs and next state; DONE can accept a new op in the same cycle its result is taken
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: in_ready = 1'b0;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: state_nx = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      if (alu_ctl == ALU_SLL && shamt != '0) state_nx = SHIFT;
      else                                   state_nx = DONE;
    end else if (state == DONE && out_ready) begin
      state_nx = IDLE;
    end else if (state == SHIFT && cnt == SHAMT_W'(1)) begin
      state_nx = DONE;
    end
  end

  // Datapath: capture single-cycle results on accept, otherwise step the shifter; the final shift writes straight into the result so latency is shamt+1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg      <= '0;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      if (alu_ctl == ALU_SLL) begin
        sreg      <= opb;
        cnt       <= shamt;
        result_q  <= opb;
        illegal_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        result_q  <= core_result;
        illegal_q <= core_illegal;
        ovf_q     <= core_ovf;
      end
    end else if (state == SHIFT) begin
      sreg <= sreg << 1;
      cnt  <= cnt - SHAMT_W'(1);
      if (cnt == SHAMT_W'(1)) result_q <= sreg << 1;
    end
  end

  assign result  = result_q;
  assign zero    = (result_q == '0);
  assign illegal = illegal_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized ops
// against a behavioural reference model, backpressure and reset-abort sequences.
// Honours ALU_OVF_EN to decide whether the overflow flag is expected.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef ALU_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic        ovf_raw;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  alu_exec_unit #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctl  (alu_ctl),
    .opa      (opa),
    .opb      (opb),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Reference model from the operation definitions using plain integer arithmetic
  function automatic void refModel(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, output logic [31:0] res, output logic ill,
                                   output logic ovf_raw, output int lat);
    longint sa;
    longint sb;
    longint wide;
    sa      = longint'(int'(a));
    sb      = longint'(int'(b));
    res     = 32'd0;
    ill     = 1'b0;
    ovf_raw = 1'b0;
    lat     = 1;
    case (ctl)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2: begin
        wide    = sa + sb;
        res     = wide[31:0];
        ovf_raw = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd6: begin
        wide    = sa - sb;
        res     = wide[31:0];
        ovf_raw = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: res = ~(a | b);
      4'd13: begin
        res = b << sh;
        lat = int'(sh) + 1;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Present one op with out_ready=1, wait (bounded) for its result and compare everything
  task automatic applyStimulus(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_res,
                               input logic exp_zero, input logic exp_ill, input logic exp_ovf_raw,
                               input int exp_lat);
    int lat;
    int busy;
    in_valid  = 1'b1;
    alu_ctl   = ctl;
    opa       = a;
    opb       = b;
    shamt     = sh;
    out_ready = 1'b1;
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " busy"}, 64'(busy), 64'(exp_lat - 1));
    checkOutput({tag, " result"}, 64'(result), 64'(exp_res));
    checkOutput({tag, " zero"}, 64'(zero), 64'(exp_zero));
    checkOutput({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(exp_ovf_raw & OVF_EN));
  endtask

  initial begin
    logic [3:0]  codes[10];
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        il;
    logic        ov;
    int          lt;
    int          seen;

    vecs[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{4'd6,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'd0,  32'hF0F0F0F0, 32'h3C3C3C3C, 5'd0,  32'h30303030, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd1,  32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd12, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'd6,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd5,  32'h0000DEAD, 32'h0000BEEF, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{4'd13, 32'h12345678, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 32};
    vecs[11] = '{4'd13, 32'h00000000, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'd13, 32'h00000000, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 5};
    vecs[13] = '{4'd15, 32'h00000003, 32'h00000004, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0, 1};

    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd5, 4'd3, 4'd15};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctl   = 4'd0;
    opa       = 32'd0;
    opb       = 32'd0;
    shamt     = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset zero", 64'(zero), 64'd1);
    checkOutput("reset illegal", 64'(illegal), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].sh,
                    vecs[i].res, vecs[i].zero, vecs[i].ill, vecs[i].ovf_raw, vecs[i].lat);
    end

    $display("[TB] randomized ops against reference model");
    for (int i = 0; i < 40; i++) begin
      c  = codes[$urandom_range(0, 9)];
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) b = (a[0]) ? a : 32'h7FFFFFFF;
      sh = 5'($urandom_range(0, 31));
      refModel(c, a, b, sh, r, il, ov, lt);
      applyStimulus($sformatf("rnd%0d", i), c, a, b, sh, r, (r == 32'd0), il, ov, lt);
    end

    $display("[TB] backpressure sequence");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    alu_ctl   = 4'd0;
    opa       = 32'hF0F01234;
    opb       = 32'h0FF0FFFF;
    out_ready = 1'b0;
    @(negedge clk);
    alu_ctl = 4'd1;
    opa     = 32'h00FF0000;
    opb     = 32'h000000AA;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp hold%0d result", i), 64'(result), 64'h00F01234);
      checkOutput($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
      if (i < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp or out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp or result", 64'(result), 64'h00FF00AA);
    @(negedge clk);
    checkOutput("bp drained out_valid", 64'(out_valid), 64'd0);

    $display("[TB] reset during SLL");
    in_valid = 1'b1;
    alu_ctl  = 4'd13;
    opb      = 32'h00000003;
    shamt    = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort result", 64'(result), 64'd0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("abort no result", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
